reg_bank_8x32_wr: RTL
=====================

// Module: reg_bank_8x32_wr
// PURPOSE
//   Write side of the 8-entry 32-bit register bank that feeds the 8x1 32-bit read mux.
//   Accepts write requests over a valid/ready handshake and decodes the 3-bit select.
//   Applies a byte-enabled write to exactly one of eight registers.
//   Also runs a sequenced clear-all. Outputs q0..q7 connect directly to read-mux inputs A..H.
// PARAMETERS
//   RST_VAL   32'h0000_0000   value loaded into every register on reset and on clear-all
// PORTS
//   clk       in   1    single clock; all state updates on rising edge
//   reset     in   1    synchronous, active-high reset
//   wr_valid  in   1    write request valid
//   wr_ready  out  1    block can accept a write or clear this cycle
//   wr_sel    in   3    target register index 0..7 (3'b000 -> q0 ... 3'b111 -> q7)
//   wr_data   in   32   write data
//   wr_be     in   4    byte enables; bit i controls data[8i+7:8i]
//   clr_all   in   1    request to clear all registers (sampled like a write, shares wr_ready)
//   q0..q7    out  32   register contents (q0 -> mux A ... q7 -> mux H)
//   reg_vld   out  8    bit i set once register i has received a non-empty write since last clear
//   wr_done   out  1    one-cycle pulse: a write has committed
//   clr_done  out  1    one-cycle pulse: clear-all has finished
// BEHAVIOUR
//   Reset (reset=1 at an edge), values after that edge:
//     q0..q7=RST_VAL, reg_vld=0, state=IDLE, wr_ready=1, wr_done=0, clr_done=0.
//     Any pending write or clear is discarded; reset overrides every other input.
//   FSM states are IDLE, WRITE and CLEAR. wr_ready = (state==IDLE), as a combinational decode of state.
//   IDLE:
//     - clr_all=1 -> CLEAR, with cnt=0. clr_all wins over a simultaneous wr_valid, and that write is NOT accepted.
//     - else wr_valid=1 -> latch sel/data/be into the stage register, then WRITE.
//     - else stay in IDLE.
//   WRITE (exactly 1 cycle):
//     - At the exiting edge, q[sel] byte lanes with be=1 take the new data; be=0 lanes hold.
//     - reg_vld[sel] is set if be!=0. All other registers are unchanged.
//     - wr_done=1 for the one cycle after that edge. Go to IDLE.
//     - be=4'b0000 is legal: no data change, reg_vld unchanged, wr_done still pulses.
//   CLEAR (8 cycles):
//     - At each edge, q[cnt]=RST_VAL and reg_vld[cnt]=0; then cnt=cnt+1.
//     - At cnt=7 the edge also goes to IDLE; clr_done=1 for the following cycle.
//     - The 3-bit cnt wraps 7->0 and is never observed outside CLEAR.
//     - Inputs (wr_valid, clr_all) are ignored while in CLEAR; wr_ready=0.
//   Latency:
//     - Write accepted at edge E0: q updates at E1; wr_done is high in the cycle after E1.
//     - Max throughput is 1 write per 2 cycles.
//     - Clear accepted at E0: registers zeroed over E1..E8; clr_done is high in the cycle after E8.
//   Output timing:
//     - q outputs are registered with no combinational path from wr_* inputs.
//     - A write to the register currently selected by the read mux appears on mux Y in the cycle after E1.
//   Requesters must hold wr_valid/wr_sel/wr_data/wr_be stable until wr_ready=1 (no drop-on-stall).
//   Reset asserted in WRITE or CLEAR: abort immediately, apply the reset values above, and do not pulse wr_done or clr_done.
// TESTING
//   T1 reset:
//     Pre-load random values, then assert reset 1 cycle -> all q=RST_VAL, reg_vld=8'h00, wr_ready=1.
//   T2 full write:
//     sel=3'b101, data=32'hDEADBEEF, be=4'hF -> q5=DEADBEEF at E1, reg_vld=8'h20, wr_done 1 cycle, others unchanged.
//   T3 byte enables:
//     q2=32'h11223344, then write data=32'hAABBCCDD, be=4'b0101 -> q2=32'h11BB33DD.
//     Then be=4'b0000 -> q2 unchanged, wr_done still pulses.
//   T4 all selects:
//     Back-to-back writes sel 0..7 with data=32'h100+i -> each qi correct.
//     wr_ready low every other cycle; reg_vld=8'hFF; read mux Y matches qi for every S.
//   T5 clear priority:
//     clr_all=1 and wr_valid=1 in the same IDLE cycle -> write not taken, wr_ready=0 for 8 cycles.
//     All q=RST_VAL, reg_vld=0, clr_done pulse after the 8th edge; re-issued write then succeeds.
//   T6 reset mid-operation:
//     Assert reset in the WRITE cycle -> target q=RST_VAL, no wr_done.
//     Assert reset at CLEAR cnt=3 -> state IDLE, no clr_done.

Source files
------------

// File: rtl/reg_bank_8x32_wr.sv
// Write side of the 8x32 register bank: valid/ready write port with byte enables,
// plus a sequenced clear-all that walks one register per cycle.
module reg_bank_8x32_wr #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    input  logic        clr_all,
    output logic [31:0] q0,
    output logic [31:0] q1,
    output logic [31:0] q2,
    output logic [31:0] q3,
    output logic [31:0] q4,
    output logic [31:0] q5,
    output logic [31:0] q6,
    output logic [31:0] q7,
    output logic [7:0]  reg_vld,
    output logic        wr_done,
    output logic        clr_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  sel_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic [31:0] regs [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            sel_q    <= 3'd0;
            data_q   <= 32'h0;
            be_q     <= 4'h0;
            reg_vld  <= 8'h00;
            wr_done  <= 1'b0;
            clr_done <= 1'b0;
            // NOTE: the bank is a set of flops, not a RAM, so every entry can and must take RST_VAL here.
            for (int i = 0; i < 8; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            // NOTE: non-blocking throughout; pulses default low and are raised only by the states below.
            wr_done  <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_all) begin
                        state <= CLEAR;
                        cnt   <= 3'd0;
                    end else if (wr_valid) begin
                        sel_q  <= wr_sel;
                        data_q <= wr_data;
                        be_q   <= wr_be;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_q[b]) begin
                            regs[sel_q][8*b +: 8] <= data_q[8*b +: 8];
                        end
                    end
                    if (be_q != 4'h0) begin
                        reg_vld[sel_q] <= 1'b1;
                    end
                    wr_done <= 1'b1;
                    state   <= IDLE;
                end
                CLEAR: begin
                    regs[cnt]    <= RST_VAL;
                    reg_vld[cnt] <= 1'b0;
                    cnt          <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        clr_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_ready = (state == IDLE);

    assign q0 = regs[0];
    assign q1 = regs[1];
    assign q2 = regs[2];
    assign q3 = regs[3];
    assign q4 = regs[4];
    assign q5 = regs[5];
    assign q6 = regs[6];
    assign q7 = regs[7];

endmodule
